// File: rtl/deskew_pkg.sv
// Shared types and constants for the deskew sequencer and its register block.
package deskew_pkg;

    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned DIM_W   = 9;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned MAX_DIM = 256;

    localparam int unsigned PROD_W = 2 * DIM_W;
    localparam int unsigned SPAN_W = ((ADDR_W > PROD_W) ? ADDR_W : PROD_W) + 1;

    localparam int unsigned FLAG_DONE        = 0;
    localparam int unsigned FLAG_ERR_SIZE    = 1;
    localparam int unsigned FLAG_MEM_ACC_ERR = 2;
    localparam int unsigned FLAG_NUM         = 3;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        FINISH,
        ERR_SIZE,
        MEM_ERR
    } deskew_st_e;

    // True when base + w*w - 1 still lies inside the address space (no wrap).
    function automatic logic span_fits(input logic [ADDR_W-1:0] base,
                                       input logic [DIM_W-1:0]  w);
        logic [PROD_W-1:0] prod;
        logic [SPAN_W-1:0] last;
        prod = PROD_W'(w) * PROD_W'(w);
        last = SPAN_W'(base) + SPAN_W'(prod) - SPAN_W'(1);
        return (last < (SPAN_W'(1) << ADDR_W));
    endfunction

endpackage

// File: rtl/deskew_if.sv
// Single shared memory port used by the deskew sequencer.
interface deskew_if;
    import deskew_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_wdata;
    logic              mem_gnt;
    logic              mem_err;
    logic              mem_rvalid;
    logic [PIX_W-1:0]  mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_err, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_err, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/deskew_addr_gen.sv
// Pixel walker: row/column counters and incremental source/destination addresses.
// Outputs reflect the counter values that will hold after this clock edge.
module deskew_addr_gen
    import deskew_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_adv,
    input  logic [DIM_W-1:0]  i_w,
    input  logic [ADDR_W-1:0] i_base_in,
    input  logic [ADDR_W-1:0] i_base_out,
    output logic [ADDR_W-1:0] o_src_c,
    output logic [ADDR_W-1:0] o_dst_c,
    output logic              o_last_c
);

    logic [DIM_W-1:0]  r_row_idx, r_col, r_dcol;
    logic [ADDR_W-1:0] r_row_base;
    logic [DIM_W-1:0]  w_row_idx_nxt, w_col_nxt, w_dcol_nxt;
    logic [ADDR_W-1:0] w_row_base_nxt;
    logic [DIM_W-1:0]  w_w_m1;
    logic [DIM_W-1:0]  w_row_idx_p1;

    assign w_w_m1       = i_w - DIM_W'(1);
    assign w_row_idx_p1 = r_row_idx + DIM_W'(1);

    // Row base steps by W per row; destination column wraps and reloads to (r+1) mod W.
    always_comb begin
        w_row_idx_nxt  = r_row_idx;
        w_col_nxt      = r_col;
        w_dcol_nxt     = r_dcol;
        w_row_base_nxt = r_row_base;
        if (i_load) begin
            w_row_idx_nxt  = '0;
            w_col_nxt      = '0;
            w_dcol_nxt     = '0;
            w_row_base_nxt = '0;
        end else if (i_adv) begin
            if (r_col == w_w_m1) begin
                w_col_nxt      = '0;
                w_row_idx_nxt  = w_row_idx_p1;
                w_row_base_nxt = r_row_base + ADDR_W'(i_w);
                w_dcol_nxt     = (w_row_idx_p1 == i_w) ? '0 : w_row_idx_p1;
            end else begin
                w_col_nxt  = r_col + DIM_W'(1);
                w_dcol_nxt = (r_dcol == w_w_m1) ? '0 : r_dcol + DIM_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_idx  <= '0;
            r_col      <= '0;
            r_dcol     <= '0;
            r_row_base <= '0;
        end else begin
            r_row_idx  <= w_row_idx_nxt;
            r_col      <= w_col_nxt;
            r_dcol     <= w_dcol_nxt;
            r_row_base <= w_row_base_nxt;
        end
    end

    assign o_src_c  = i_base_in  + w_row_base_nxt + ADDR_W'(w_col_nxt);
    assign o_dst_c  = i_base_out + w_row_base_nxt + ADDR_W'(w_dcol_nxt);
    assign o_last_c = (r_row_idx == w_w_m1) && (r_col == w_w_m1);

endmodule

// File: rtl/deskew_ctrl.sv
// Deskew sequencer: validates the image size, then reads and writes each pixel
// through one shared memory port and reports sticky status flags.
module deskew_ctrl
    import deskew_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_deskew,
    input  logic              soft_rst,
    input  logic [DIM_W-1:0]  img_w_l,
    input  logic [ADDR_W-1:0] start_addr_in,
    input  logic [ADDR_W-1:0] start_addr_out,
    input  logic              mem_acc_err_ack,
    input  logic              err_size_ack,
    input  logic              done_ack,
    output logic              mem_acc_err,
    output logic              err_size,
    output logic              done,
    output logic              idle,
    deskew_if.master          mem
);

    deskew_st_e          r_state, w_state_nxt;
    logic [DIM_W-1:0]    r_w;
    logic [ADDR_W-1:0]   r_base_in, r_base_out;
    logic [FLAG_NUM-1:0] r_flags, w_flags_nxt, w_ack;
    logic                r_idle;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [PIX_W-1:0]    r_mem_wdata, w_mem_wdata_nxt;
    logic                w_cap, w_load, w_adv, w_size_ok;
    logic [ADDR_W-1:0]   w_src, w_dst;
    logic                w_last;

    deskew_addr_gen u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_adv      (w_adv),
        .i_w        (r_w),
        .i_base_in  (r_base_in),
        .i_base_out (r_base_out),
        .o_src_c    (w_src),
        .o_dst_c    (w_dst),
        .o_last_c   (w_last)
    );

    assign w_size_ok = (r_w != '0) && (r_w <= DIM_W'(MAX_DIM))
                    && span_fits(r_base_in, r_w) && span_fits(r_base_out, r_w);

    always_comb begin
        w_ack                   = '0;
        w_ack[FLAG_DONE]        = done_ack;
        w_ack[FLAG_ERR_SIZE]    = err_size_ack;
        w_ack[FLAG_MEM_ACC_ERR] = mem_acc_err_ack;
    end

    // Next state and next registered outputs; flag sets override same-cycle acks.
    always_comb begin
        w_state_nxt     = r_state;
        w_flags_nxt     = r_flags & ~w_ack;
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cap           = 1'b0;
        w_load          = 1'b0;
        w_adv           = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_deskew) begin
                    w_state_nxt = CHECK;
                    w_cap       = 1'b1;
                end
            end
            CHECK: begin
                if (w_size_ok) begin
                    w_state_nxt    = RD_REQ;
                    w_load         = 1'b1;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = w_src;
                end else begin
                    w_state_nxt = ERR_SIZE;
                end
            end
            RD_REQ: begin
                if (mem.mem_gnt) begin
                    w_state_nxt = mem.mem_err ? MEM_ERR : RD_WAIT;
                end else begin
                    w_mem_req_nxt = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem.mem_rvalid) begin
                    w_state_nxt     = WR_REQ;
                    w_mem_wdata_nxt = mem.mem_rdata;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = w_dst;
                end
            end
            WR_REQ: begin
                if (mem.mem_gnt) begin
                    if (mem.mem_err) begin
                        w_state_nxt = MEM_ERR;
                    end else if (w_last) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt    = RD_REQ;
                        w_adv          = 1'b1;
                        w_mem_req_nxt  = 1'b1;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = w_src;
                    end
                end else begin
                    w_mem_req_nxt = 1'b1;
                end
            end
            FINISH: begin
                w_flags_nxt[FLAG_DONE] = 1'b1;
                w_state_nxt            = IDLE;
            end
            ERR_SIZE: begin
                w_flags_nxt[FLAG_ERR_SIZE] = 1'b1;
                w_state_nxt                = IDLE;
            end
            MEM_ERR: begin
                w_flags_nxt[FLAG_MEM_ACC_ERR] = 1'b1;
                w_state_nxt                   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (soft_rst) begin
            w_state_nxt   = IDLE;
            w_flags_nxt   = '0;
            w_mem_req_nxt = 1'b0;
            w_cap         = 1'b0;
            w_load        = 1'b0;
            w_adv         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flags     <= '0;
            r_idle      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flags     <= w_flags_nxt;
            r_idle      <= (w_state_nxt == IDLE);
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Run configuration is frozen at the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w        <= '0;
            r_base_in  <= '0;
            r_base_out <= '0;
        end else if (w_cap) begin
            r_w        <= img_w_l;
            r_base_in  <= start_addr_in;
            r_base_out <= start_addr_out;
        end
    end

    assign done          = r_flags[FLAG_DONE];
    assign err_size      = r_flags[FLAG_ERR_SIZE];
    assign mem_acc_err   = r_flags[FLAG_MEM_ACC_ERR];
    assign idle          = r_idle;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_deskew_ctrl.sv
// Directed bench for deskew_ctrl with a small memory model (rvalid two cycles after read grant).
module tb_deskew_ctrl;
    import deskew_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_deskew, soft_rst;
    logic [DIM_W-1:0]  img_w_l;
    logic [ADDR_W-1:0] start_addr_in, start_addr_out;
    logic              mem_acc_err_ack, err_size_ack, done_ack;
    logic              mem_acc_err, err_size, done, idle;

    deskew_if mem_if ();

    deskew_ctrl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_deskew    (start_deskew),
        .soft_rst        (soft_rst),
        .img_w_l         (img_w_l),
        .start_addr_in   (start_addr_in),
        .start_addr_out  (start_addr_out),
        .mem_acc_err_ack (mem_acc_err_ack),
        .err_size_ack    (err_size_ack),
        .done_ack        (done_ack),
        .mem_acc_err     (mem_acc_err),
        .err_size        (err_size),
        .done            (done),
        .idle            (idle),
        .mem             (mem_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0, rd_cyc = -10, gnt_cnt = 0, req_cycles = 0;
    int err_at = 0, stall_at = 0, stall_len = 0, stall_done = 0;
    logic              rd_seen = 1'b0;
    logic [ADDR_W-1:0] rd_pend_addr = '0;
    logic [ADDR_W-1:0] rd_q[$];
    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [PIX_W-1:0]  wr_data_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory side: log accepted accesses on the active edge.
    always @(posedge clk) begin
        cyc++;
        if (mem_if.mem_req === 1'b1) req_cycles++;
        if (mem_if.mem_req === 1'b1 && mem_if.mem_gnt === 1'b1) begin
            gnt_cnt++;
            if (!mem_if.mem_err) begin
                if (mem_if.mem_we) begin
                    wr_addr_q.push_back(mem_if.mem_addr);
                    wr_data_q.push_back(mem_if.mem_wdata);
                end else begin
                    rd_q.push_back(mem_if.mem_addr);
                    rd_pend_addr = mem_if.mem_addr;
                    rd_cyc       = cyc;
                    rd_seen      = 1'b1;
                end
            end
        end
    end

    // Memory side: drive responses on the falling edge.
    always @(negedge clk) begin
        mem_if.mem_rvalid = rd_seen && (cyc == rd_cyc + 1);
        mem_if.mem_rdata  = rd_pend_addr[PIX_W-1:0];
        if (mem_if.mem_req === 1'b1 && (gnt_cnt + 1 == stall_at) && stall_done < stall_len) begin
            mem_if.mem_gnt = 1'b0;
            stall_done++;
        end else begin
            mem_if.mem_gnt = (mem_if.mem_req === 1'b1);
            if (mem_if.mem_gnt) stall_done = 0;
        end
        mem_if.mem_err = mem_if.mem_gnt && (err_at != 0) && (gnt_cnt + 1 == err_at);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int w, input int base_in, input int base_out);
        img_w_l        = DIM_W'(w);
        start_addr_in  = ADDR_W'(base_in);
        start_addr_out = ADDR_W'(base_out);
        start_deskew   = 1'b1;
        step();
        start_deskew   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!idle && k < budget) begin
            step();
            k++;
        end
        check_eq("idle_reached", 32'(idle), 32'd1);
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (wr_addr_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq("wr_count", 32'(wr_addr_q.size()), 32'(n));
    endtask

    task automatic wait_rd(input int n, input int budget);
        int k = 0;
        while (rd_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq("rd_count", 32'(rd_q.size()), 32'(n));
    endtask

    task automatic wait_gnt(input int n, input int budget);
        int k = 0;
        while (gnt_cnt < n && k < budget) begin
            step();
            k++;
        end
        check_eq("gnt_count", 32'(gnt_cnt), 32'(n));
    endtask

    // Reference addresses from the closed-form mapping.
    task automatic check_run(input string tag, input int w, input int base_in, input int base_out,
                             input int rb, input int wb, input int npix);
        for (int p = 0; p < npix; p++) begin
            int r, c;
            logic [31:0] e_src, e_dst;
            logic [7:0]  e_dat;
            r     = p / w;
            c     = p % w;
            e_src = 32'(base_in + r * w + c);
            e_dst = 32'(base_out + r * w + ((c + r) % w));
            e_dat = e_src[7:0];
            check_eq({tag, "_rd"},  32'(rd_q[rb + p]),      e_src);
            check_eq({tag, "_wa"},  32'(wr_addr_q[wb + p]), e_dst);
            check_eq({tag, "_wd"},  32'(wr_data_q[wb + p]), 32'(e_dat));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rb, wb, g0, rq0;
        rst_n = 1'b0; start_deskew = 1'b0; soft_rst = 1'b0;
        img_w_l = '0; start_addr_in = '0; start_addr_out = '0;
        mem_acc_err_ack = 1'b0; err_size_ack = 1'b0; done_ack = 1'b0;
        repeat (3) step();
        check_eq("rst_idle",  32'(idle), 32'd1);
        check_eq("rst_flags", 32'({mem_acc_err, err_size, done}), 32'd0);
        check_eq("rst_req",   32'({mem_if.mem_req, mem_if.mem_we}), 32'd0);
        check_eq("rst_addr",  32'(mem_if.mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_if.mem_wdata), 32'd0);
        rst_n = 1'b1;
        step();

        // W=3 full run with cycle-exact start and done latency
        rb = rd_q.size(); wb = wr_addr_q.size();
        launch(3, 'h100, 'h200);
        img_w_l = DIM_W'(5);
        check_eq("t1_req_c1", 32'(mem_if.mem_req), 32'd0);
        step();
        check_eq("t1_req_c2", 32'(mem_if.mem_req), 32'd1);
        check_eq("t1_addr_c2", 32'(mem_if.mem_addr), 32'h100);
        check_eq("t1_we_c2", 32'(mem_if.mem_we), 32'd0);
        wait_wr(wb + 9, 300);
        check_eq("t1_done_n1", 32'(done), 32'd0);
        step();
        check_eq("t1_done_n2", 32'(done), 32'd1);
        check_eq("t1_idle_n2", 32'(idle), 32'd1);
        check_eq("t1_nrd", 32'(rd_q.size() - rb), 32'd9);
        check_run("t1", 3, 'h100, 'h200, rb, wb, 9);
        done_ack = 1'b1; step(); done_ack = 1'b0;
        check_eq("t1_done_ack", 32'(done), 32'd0);

        // Illegal sizes: W=0 then W=300 while err_size still pending
        rq0 = req_cycles;
        launch(0, 'h100, 'h200);
        wait_idle(20);
        check_eq("t2_w0_err", 32'(err_size), 32'd1);
        launch(300, 'h100, 'h200);
        check_eq("t2_pending", 32'(err_size), 32'd1);
        wait_idle(20);
        check_eq("t2_w300_err", 32'(err_size), 32'd1);
        check_eq("t2_no_req", 32'(req_cycles), 32'(rq0));
        err_size_ack = 1'b1; step(); err_size_ack = 1'b0;
        check_eq("t2_ack", 32'(err_size), 32'd0);

        // Address-space boundary cases
        launch(256, 'h10000, 'h1FF00);
        wait_idle(20);
        check_eq("t3_ovf_out", 32'(err_size), 32'd1);
        err_size_ack = 1'b1; step(); err_size_ack = 1'b0;
        launch(256, 'h10001, 'h00000);
        wait_idle(20);
        check_eq("t3_ovf_in_by1", 32'(err_size), 32'd1);
        err_size_ack = 1'b1; step(); err_size_ack = 1'b0;
        check_eq("t3_ack", 32'(err_size), 32'd0);

        rb = rd_q.size(); wb = wr_addr_q.size();
        launch(1, 'h1FFFF, 'h00005);
        wait_idle(30);
        check_eq("t3_w1_done", 32'({err_size, done}), 32'b01);
        check_eq("t3_w1_nrd", 32'(rd_q.size() - rb), 32'd1);
        check_eq("t3_w1_nwr", 32'(wr_addr_q.size() - wb), 32'd1);
        check_run("t3_w1", 1, 'h1FFFF, 'h00005, rb, wb, 1);

        rb = rd_q.size(); wb = wr_addr_q.size();
        launch(256, 'h10000, 'h00000);
        check_eq("t3_stale_done", 32'(done), 32'd1);
        wait_wr(wb + 600, 4000);
        check_eq("t3_w256_noerr", 32'(err_size), 32'd0);
        soft_rst = 1'b1; step(); soft_rst = 1'b0;
        check_eq("t3_srst_idle", 32'(idle), 32'd1);
        check_eq("t3_srst_flags", 32'({mem_acc_err, err_size, done}), 32'd0);
        check_run("t3_w256", 256, 'h10000, 'h00000, rb, wb, 600);
        step();

        // mem_err on the 5th grant (third pixel's read)
        wb = wr_addr_q.size();
        g0 = gnt_cnt;
        err_at = g0 + 5;
        launch(4, 'h500, 'h600);
        wait_gnt(g0 + 5, 100);
        check_eq("t4_req_off", 32'(mem_if.mem_req), 32'd0);
        step();
        check_eq("t4_acc_err", 32'(mem_acc_err), 32'd1);
        check_eq("t4_idle", 32'(idle), 32'd1);
        check_eq("t4_nwr", 32'(wr_addr_q.size() - wb), 32'd2);
        err_at = 0;
        rq0 = req_cycles;
        repeat (5) step();
        check_eq("t4_no_more_req", 32'(req_cycles), 32'(rq0));
        mem_acc_err_ack = 1'b1; step(); mem_acc_err_ack = 1'b0;
        check_eq("t4_ack", 32'(mem_acc_err), 32'd0);

        // soft_rst during RD_WAIT abandons the read and clears stale done
        launch(1, 'h700, 'h800);
        wait_idle(30);
        check_eq("t5_pre_done", 32'(done), 32'd1);
        rb = rd_q.size();
        launch(2, 'h300, 'h400);
        wait_rd(rb + 1, 50);
        soft_rst = 1'b1; step(); soft_rst = 1'b0;
        check_eq("t5_idle", 32'(idle), 32'd1);
        check_eq("t5_req", 32'(mem_if.mem_req), 32'd0);
        check_eq("t5_done_clr", 32'(done), 32'd0);
        wb = wr_addr_q.size(); rq0 = req_cycles;
        repeat (4) step();
        check_eq("t5_no_wr", 32'(wr_addr_q.size()), 32'(wb));
        check_eq("t5_no_req", 32'(req_cycles), 32'(rq0));
        check_eq("t5_flags", 32'({mem_acc_err, err_size, done}), 32'd0);
        img_w_l = DIM_W'(2); start_deskew = 1'b1; soft_rst = 1'b1;
        step();
        start_deskew = 1'b0; soft_rst = 1'b0;
        check_eq("t5_srst_beats_start", 32'(idle), 32'd1);
        step();
        check_eq("t5_srst_beats_req", 32'(mem_if.mem_req), 32'd0);
        rb = rd_q.size(); wb = wr_addr_q.size();
        launch(2, 'h300, 'h400);
        wait_idle(100);
        check_eq("t5_rerun_done", 32'(done), 32'd1);
        check_run("t5", 2, 'h300, 'h400, rb, wb, 4);
        done_ack = 1'b1; step(); done_ack = 1'b0;

        // Stalled grant keeps request stable; ack coinciding with FINISH loses
        rb = rd_q.size(); wb = wr_addr_q.size();
        stall_at = gnt_cnt + 1; stall_len = 5;
        launch(2, 'h900, 'hA00);
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("t6_stall_req",  32'(mem_if.mem_req), 32'd1);
            check_eq("t6_stall_addr", 32'(mem_if.mem_addr), 32'h900);
            check_eq("t6_stall_we",   32'(mem_if.mem_we), 32'd0);
            step();
        end
        stall_at = 0;
        wait_wr(wb + 4, 200);
        done_ack = 1'b1;
        check_eq("t6_done_before", 32'(done), 32'd0);
        step();
        done_ack = 1'b0;
        check_eq("t6_set_wins", 32'(done), 32'd1);
        check_run("t6", 2, 'h900, 'hA00, rb, wb, 4);

        // Asynchronous reset mid-run
        launch(3, 'h100, 'h200);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t7_async_req",  32'(mem_if.mem_req), 32'd0);
        check_eq("t7_async_idle", 32'(idle), 32'd1);
        check_eq("t7_async_flags", 32'({mem_acc_err, err_size, done}), 32'd0);
        check_eq("t7_async_addr", 32'(mem_if.mem_addr), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
